// File: rtl/xram_arb.sv
// rtl/xram_arb.sv - two-master round-robin XRAM arbiter with transfer watchdog
module xram_arb #(
  parameter int          AW      = 16,
  parameter int          DW      = 8,
  parameter int          TIMEOUT = 64,
  parameter logic [DW-1:0] TO_DATA = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_wr,
  input  logic          m0_stb,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,

  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_wr,
  input  logic          m1_stb,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,

  output logic [AW-1:0] xram_addr,
  output logic [DW-1:0] xram_data_out,
  input  logic [DW-1:0] xram_data_in,
  output logic          xram_wr,
  output logic          xram_stb,
  input  logic          xram_ack,

  input  logic          err_clr,
  output logic [1:0]    arb_owner,
  output logic          arb_err
);

  // State encoding doubles as the arb_owner status value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Counter value on the last cycle a transfer may wait before the watchdog fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic       WDOG_EN = (TIMEOUT > 0);

  state_t     state, state_d;
  logic       last_grant;
  logic [7:0] wait_cnt;

  logic       in_gnt;
  logic       sel_stb;
  logic       real_done;
  logic       to_fire;
  logic       done_ack;
  logic [DW-1:0] done_rdata;

  // State register; async reset kills any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Round-robin pointer: remembers which master was granted most recently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && state_d == GNT0) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && state_d == GNT1) begin
      last_grant <= 1'b1;
    end
  end

  // Watchdog wait counter: zero in IDLE so every grant starts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
    end else if (!in_gnt) begin
      wait_cnt <= 8'd0;
    end else if (!xram_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_err <= 1'b0;
    end else if (to_fire) begin
      arb_err <= 1'b1;
    end else if (err_clr) begin
      arb_err <= 1'b0;
    end
  end

  // Transfer completion: real ack first, watchdog only when the slave stays silent.
  always_comb begin
    in_gnt     = (state == GNT0) || (state == GNT1);
    sel_stb    = 1'b0;
    if (state == GNT0) begin
      sel_stb = m0_stb;
    end else if (state == GNT1) begin
      sel_stb = m1_stb;
    end
    real_done  = in_gnt && sel_stb && xram_ack;
    to_fire    = WDOG_EN && in_gnt && sel_stb && !xram_ack && (wait_cnt == TO_LAST);
    done_ack   = real_done || to_fire;
    done_rdata = to_fire ? TO_DATA : xram_data_in;
  end

  // Next-state and output mux; everything idles at zero outside a grant.
  always_comb begin
    state_d       = state;
    xram_addr     = '0;
    xram_data_out = '0;
    xram_wr       = 1'b0;
    xram_stb      = 1'b0;
    m0_ack        = 1'b0;
    m0_rdata      = '0;
    m1_ack        = 1'b0;
    m1_rdata      = '0;

    case (state)
      IDLE: begin
        if (m0_stb && !m1_stb) begin
          state_d = GNT0;
        end else if (m1_stb && !m0_stb) begin
          state_d = GNT1;
        end else if (m0_stb && m1_stb) begin
          state_d = last_grant ? GNT0 : GNT1;
        end
      end

      GNT0: begin
        xram_addr     = m0_addr;
        xram_data_out = m0_wdata;
        xram_wr       = m0_wr;
        xram_stb      = m0_stb;
        m0_rdata      = done_rdata;
        m0_ack        = done_ack;
        // Abort (strobe dropped) or completion both release the slave.
        if (!m0_stb || done_ack) begin
          state_d = IDLE;
        end
      end

      GNT1: begin
        xram_addr     = m1_addr;
        xram_data_out = m1_wdata;
        xram_wr       = m1_wr;
        xram_stb      = m1_stb;
        m1_rdata      = done_rdata;
        m1_ack        = done_ack;
        if (!m1_stb || done_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign arb_owner = state;

endmodule

// File: tb/tb_xram_arb.sv
// tb/tb_xram_arb.sv - directed self-checking bench for xram_arb
module tb_xram_arb;

  logic        clk;
  logic        rst;
  logic [15:0] m0_addr, m1_addr, xram_addr;
  logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [7:0]  xram_data_out, xram_data_in;
  logic        m0_wr, m0_stb, m0_ack;
  logic        m1_wr, m1_stb, m1_ack;
  logic        xram_wr, xram_stb, xram_ack;
  logic        err_clr, arb_err;
  logic [1:0]  arb_owner;

  int tests  = 0;
  int errors = 0;

  xram_arb #(
    .AW(16), .DW(8), .TIMEOUT(4), .TO_DATA(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr), .m0_stb(m0_stb),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr), .m1_stb(m1_stb),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_data_in(xram_data_in),
    .xram_wr(xram_wr), .xram_stb(xram_stb), .xram_ack(xram_ack),
    .err_clr(err_clr), .arb_owner(arb_owner), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then move 2ns clear of it before driving.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    m0_addr = '0; m0_wdata = '0; m0_wr = 1'b0; m0_stb = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wr = 1'b0; m1_stb = 1'b0;
    xram_data_in = '0; xram_ack = 1'b0; err_clr = 1'b0;

    #12;
    check("rst_owner", 32'(arb_owner), 32'd0);
    check("rst_stb",   32'(xram_stb),  32'd0);
    check("rst_addr",  32'(xram_addr), 32'd0);
    check("rst_err",   32'(arb_err),   32'd0);
    check("rst_ack",   32'({m0_ack, m1_ack}), 32'd0);
    rst = 1'b1;

    // Single read from m1, slave acks on the 4th grant cycle (also the watchdog cycle).
    step();
    m1_stb = 1'b1; m1_addr = 16'h0100; m1_wr = 1'b0;
    #1 check("rd_idle_stb", 32'(xram_stb), 32'd0);
    step(); #1;
    check("rd_owner", 32'(arb_owner), 32'd2);
    check("rd_stb",   32'(xram_stb),  32'd1);
    check("rd_addr",  32'(xram_addr), 32'h0100);
    check("rd_wr",    32'(xram_wr),   32'd0);
    step(); #1 check("rd_c2_ack", 32'(m1_ack), 32'd0);
    step(); #1 check("rd_c3_ack", 32'(m1_ack), 32'd0);
    step();
    xram_ack = 1'b1; xram_data_in = 8'h5A;
    #1;
    check("rd_ack",    32'(m1_ack),   32'd1);
    check("rd_rdata",  32'(m1_rdata), 32'h5A);
    check("rd_m0_ack", 32'(m0_ack),   32'd0);
    check("rd_m0_rd",  32'(m0_rdata), 32'd0);
    step();
    m1_stb = 1'b0; xram_ack = 1'b0; xram_data_in = '0;
    #1;
    check("rd_done_owner", 32'(arb_owner), 32'd0);
    check("rd_done_ack",   32'(m1_ack),    32'd0);
    check("rd_no_err",     32'(arb_err),   32'd0);

    // Tie after reset alternates m0, m1, m0, m1.
    rst = 1'b0; #1; rst = 1'b1;
    m0_stb = 1'b1; m0_addr = 16'hA000; m0_wr = 1'b1; m0_wdata = 8'h11;
    m1_stb = 1'b1; m1_addr = 16'hB000; m1_wr = 1'b1; m1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      xram_ack = 1'b1;
      #1;
      check("tie_owner", 32'(arb_owner), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("tie_addr",  32'(xram_addr), (i % 2 == 0) ? 32'hA000 : 32'hB000);
      check("tie_m0ack", 32'(m0_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("tie_m1ack", 32'(m1_ack), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      xram_ack = 1'b0;
      #1 check("tie_idle", 32'(arb_owner), 32'd0);
    end
    m0_stb = 1'b0; m1_stb = 1'b0;

    // Write path from m0.
    step();
    m0_stb = 1'b1; m0_addr = 16'hF000; m0_wdata = 8'hC3; m0_wr = 1'b1;
    step(); #1;
    check("wr_owner", 32'(arb_owner),     32'd1);
    check("wr_wr",    32'(xram_wr),       32'd1);
    check("wr_data",  32'(xram_data_out), 32'hC3);
    check("wr_addr",  32'(xram_addr),     32'hF000);
    xram_ack = 1'b1;
    #1 check("wr_ack", 32'(m0_ack), 32'd1);
    step();
    m0_stb = 1'b0; m0_wr = 1'b0; xram_ack = 1'b0;

    // Ack while idle is not routed anywhere.
    step();
    xram_ack = 1'b1; xram_data_in = 8'h77;
    #1;
    check("idle_ack",   32'({m0_ack, m1_ack}), 32'd0);
    check("idle_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    step();
    xram_ack = 1'b0; xram_data_in = '0;
    #1 check("idle_owner", 32'(arb_owner), 32'd0);

    // Watchdog: m0 read, slave never acks.
    m0_stb = 1'b1; m0_addr = 16'h1234;
    step(); #1 check("to_c1_ack", 32'(m0_ack), 32'd0);
    step(); #1 check("to_c2_ack", 32'(m0_ack), 32'd0);
    step(); #1 check("to_c3_ack", 32'(m0_ack), 32'd0);
    step(); #1;
    check("to_ack",   32'(m0_ack),   32'd1);
    check("to_rdata", 32'(m0_rdata), 32'hFF);
    check("to_stb",   32'(xram_stb), 32'd1);
    check("to_err0",  32'(arb_err),  32'd0);
    step();
    m0_stb = 1'b0;
    #1;
    check("to_err1",  32'(arb_err),   32'd1);
    check("to_owner", 32'(arb_owner), 32'd0);
    step(); #1 check("to_err_held", 32'(arb_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    #1 check("to_err_clr", 32'(arb_err), 32'd0);

    // Timeout on m1 with err_clr asserted the same cycle: set wins.
    m1_stb = 1'b1; m1_wr = 1'b0;
    step(); step(); step(); step();
    err_clr = 1'b1;
    #1 check("to2_ack", 32'(m1_ack), 32'd1);
    step();
    m1_stb = 1'b0; err_clr = 1'b0;
    #1 check("to2_set_wins", 32'(arb_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    #1 check("to2_clr", 32'(arb_err), 32'd0);

    // Abort: m1 drops strobe on the 2nd grant cycle.
    m1_stb = 1'b1;
    step(); #1 check("ab_stb1", 32'(xram_stb), 32'd1);
    step();
    m1_stb = 1'b0;
    #1;
    check("ab_stb0", 32'(xram_stb), 32'd0);
    check("ab_ack",  32'(m1_ack),   32'd0);
    step(); #1;
    check("ab_owner", 32'(arb_owner), 32'd0);
    check("ab_err",   32'(arb_err),   32'd0);

    // Reset mid-transfer, then a tie must go to m0 again.
    m0_stb = 1'b1;
    step(); #1 check("rm_stb1", 32'(xram_stb), 32'd1);
    rst = 1'b0;
    #1;
    check("rm_stb0",  32'(xram_stb),  32'd0);
    check("rm_owner", 32'(arb_owner), 32'd0);
    check("rm_ack",   32'(m0_ack),    32'd0);
    rst = 1'b1;
    m1_stb = 1'b1;
    step(); #1 check("rm_tie_owner", 32'(arb_owner), 32'd1);
    m0_stb = 1'b0; m1_stb = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench timed out");
    $fatal(1);
  end

endmodule
